// File: rtl/vga_scan_gen.sv
// Raster scan generator and registered pixel output stage for a VGA display.
// Produces draw coordinates, then masks, syncs and registers the returned colour.
module vga_scan_gen #(
  parameter int H_ACTIVE = 1440,
  parameter int H_FP     = 80,
  parameter int H_SYNC   = 152,
  parameter int H_BP     = 232,
  parameter int V_ACTIVE = 900,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 28,
  parameter int H_POL    = 0,
  parameter int V_POL    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  output logic [10:0] draw_x,
  output logic [9:0]  draw_y,
  output logic        active,
  input  logic [3:0]  draw_r,
  input  logic [3:0]  draw_g,
  input  logic [3:0]  draw_b,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOT - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
  localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
  localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);
  localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic        HS_ON    = (H_POL != 0);
  localparam logic        VS_ON    = (V_POL != 0);

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        h_end;
  logic        v_end;
  logic        hs_win;
  logic        vs_win;

  assign h_end  = (h_cnt == H_LAST);
  assign v_end  = (v_cnt == V_LAST);
  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_win = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
  assign vs_win = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
  assign draw_x = h_cnt;
  assign draw_y = v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Captures the pre-increment position so colour and syncs stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= ~HS_ON;
      vga_vs      <= ~VS_ON;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        vga_r       <= active ? draw_r : 4'd0;
        vga_g       <= active ? draw_g : 4'd0;
        vga_b       <= active ? draw_b : 4'd0;
        vga_hs      <= hs_win ? HS_ON : ~HS_ON;
        vga_vs      <= vs_win ? VS_ON : ~VS_ON;
        frame_start <= h_end && v_end;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Randomised self-checking bench for vga_scan_gen on a shrunk raster so that
// several whole frames fit in a short run; expectations come from pixel-count arithmetic.
module tb_vga_scan_gen;

  localparam int HA = 16, HFP = 4, HSW = 6, HBP = 5;
  localparam int VA = 8,  VFP = 1, VSW = 2, VBP = 3;
  localparam int HPOL = 0, VPOL = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [10:0] draw_x;
  logic [9:0]  draw_y;
  logic        active;
  logic [3:0]  draw_r, draw_g, draw_b;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: pixel strobes seen since reset release plus expected registers.
  int         n;
  logic [3:0] exp_r, exp_g, exp_b;
  logic       exp_hs, exp_vs, exp_fs;
  int         fs_count;

  vga_scan_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .H_POL(HPOL), .V_POL(VPOL)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .draw_x(draw_x), .draw_y(draw_y), .active(active),
    .draw_r(draw_r), .draw_g(draw_g), .draw_b(draw_b),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, expv, n);
    end
  endtask

  task automatic modelReset();
    n      = 0;
    exp_r  = 4'd0;
    exp_g  = 4'd0;
    exp_b  = 4'd0;
    exp_hs = ~1'(HPOL);
    exp_vs = ~1'(VPOL);
    exp_fs = 1'b0;
  endtask

  task automatic checkAll();
    int x, y;
    x = n % HT;
    y = (n / HT) % VT;
    checkOutput("draw_x", 32'(draw_x), 32'(x));
    checkOutput("draw_y", 32'(draw_y), 32'(y));
    checkOutput("active", 32'(active), 32'((x < HA) && (y < VA)));
    checkOutput("vga_r", 32'(vga_r), 32'(exp_r));
    checkOutput("vga_g", 32'(vga_g), 32'(exp_g));
    checkOutput("vga_b", 32'(vga_b), 32'(exp_b));
    checkOutput("vga_hs", 32'(vga_hs), 32'(exp_hs));
    checkOutput("vga_vs", 32'(vga_vs), 32'(exp_vs));
    checkOutput("frame_start", 32'(frame_start), 32'(exp_fs));
  endtask

  // One clock: drive random colour, predict the registered result, then compare.
  task automatic applyStimulus(input logic pe);
    int x, y;
    logic vis;
    pix_en = pe;
    draw_r = 4'($urandom);
    draw_g = 4'($urandom);
    draw_b = 4'($urandom);
    x = n % HT;
    y = (n / HT) % VT;
    if (pe) begin
      vis    = (x < HA) && (y < VA);
      exp_r  = vis ? draw_r : 4'd0;
      exp_g  = vis ? draw_g : 4'd0;
      exp_b  = vis ? draw_b : 4'd0;
      exp_hs = (x >= HA + HFP && x < HA + HFP + HSW) ? 1'(HPOL) : ~1'(HPOL);
      exp_vs = (y >= VA + VFP && y < VA + VFP + VSW) ? 1'(VPOL) : ~1'(VPOL);
      exp_fs = (x == HT - 1) && (y == VT - 1);
      n++;
    end else begin
      exp_fs = 1'b0;
    end
    @(posedge clk);
    #1;
    if (frame_start === 1'b1) fs_count++;
    checkAll();
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b1;
    draw_r = 4'hF;
    draw_g = 4'hF;
    draw_b = 4'hF;
    fs_count = 0;
    modelReset();
    repeat (3) @(posedge clk);
    #1;
    checkAll();
    checkOutput("reset_hs_level", 32'(vga_hs), 32'd1);
    checkOutput("reset_vs_level", 32'(vga_vs), 32'd0);

    rst = 1'b0;
    $display("[TB] free-running scan, three frames");
    for (int i = 0; i < 3 * FT + 5; i++) applyStimulus(1'b1);
    checkOutput("frame_pulses_free_run", 32'(fs_count), 32'd3);

    $display("[TB] pix_en alternating and random stalls");
    fs_count = 0;
    for (int i = 0; i < 2 * FT; i++) applyStimulus(1'(i % 2 == 0));
    for (int i = 0; i < 2 * FT; i++) applyStimulus(1'($urandom_range(0, 2) != 0));
    checkOutput("frame_pulses_stalled", 32'(fs_count), 32'((n / FT) - 3));

    $display("[TB] reset mid-frame");
    for (int i = 0; i < FT && !((n % HT == HA / 2) && ((n / HT) % VT == VA / 2)); i++)
      applyStimulus(1'b1);
    checkOutput("reached_mid_frame", 32'(n % HT + 100 * ((n / HT) % VT)), 32'(HA / 2 + 100 * (VA / 2)));
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    @(posedge clk);
    #3;
    rst = 1'b0;
    fs_count = 0;
    for (int i = 0; i < FT + 3; i++) applyStimulus(1'b1);
    checkOutput("frame_pulses_after_reset", 32'(fs_count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
